// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl: aligns to a frame boundary after arm and streams pixels to the frame buffer
// with row-major addressing, row/column counters and sticky short-line/short-frame status.
module camera_capture_ctrl #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_WIDTH = 17,
    localparam int HW = $clog2(H_ACTIVE + 1),
    localparam int VW = $clog2(V_ACTIVE + 1)
) (
    input  logic                  clk_pixel_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    input  logic [15:0]           data_in,
    input  logic                  hs_in,
    input  logic                  vs_in,
    input  logic                  arm_in,
    input  logic                  continuous_in,
    output logic                  we_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [15:0]           pixel_out,
    output logic [HW-1:0]         hcount_out,
    output logic [VW-1:0]         vcount_out,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic                  line_err_out,
    output logic                  frame_err_out
);
    typedef enum logic [1:0] {IDLE, SYNC_LOW, SYNC_HIGH, CAPTURE} state_t;
    localparam logic [HW-1:0] H_LIM = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LIM = VW'(V_ACTIVE);
    state_t state;
    logic hs_prev, vs_prev, hs_fall, vs_rise, vs_fall, accept, line_adv;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    always_comb begin
        hs_fall = hs_prev & ~hs_in;
        vs_rise = ~vs_prev & vs_in;
        vs_fall = vs_prev & ~vs_in;
        accept = (state == CAPTURE) && valid_in && hs_in && vs_in && (hcount_out < H_LIM) && (vcount_out < V_LIM);
        line_adv = hs_fall && (vcount_out < V_LIM);
        h_next = hcount_out + HW'(accept);
        v_next = line_adv ? vcount_out + VW'(1) : vcount_out;
    end
    assign busy_out = (state != IDLE);
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state <= IDLE;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            we_out <= 1'b0;
            addr_out <= '0;
            pixel_out <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            wr_addr <= '0;
            frame_done_out <= 1'b0;
            line_err_out <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            hs_prev <= hs_in;
            vs_prev <= vs_in;
            we_out <= accept;
            frame_done_out <= 1'b0;
            if (accept) begin
                addr_out <= wr_addr;
                pixel_out <= data_in;
            end
            case (state)
                IDLE: if (arm_in) begin
                    state <= SYNC_LOW;
                    line_err_out <= 1'b0;
                    frame_err_out <= 1'b0;
                end
                SYNC_LOW: if (!vs_in) state <= SYNC_HIGH;
                SYNC_HIGH: if (vs_rise) begin
                    state <= CAPTURE;
                    hcount_out <= '0;
                    vcount_out <= '0;
                    wr_addr <= '0;
                end
                CAPTURE: begin
                    hcount_out <= h_next;
                    wr_addr <= wr_addr + ADDR_WIDTH'(accept);
                    // next line base = current base + H_ACTIVE, derived from the column position
                    if (line_adv) begin
                        line_err_out <= line_err_out | (h_next < H_LIM);
                        hcount_out <= '0;
                        vcount_out <= v_next;
                        wr_addr <= wr_addr + ADDR_WIDTH'(H_ACTIVE) - ADDR_WIDTH'(hcount_out);
                    end
                    if (vs_fall) begin
                        frame_done_out <= 1'b1;
                        frame_err_out <= frame_err_out | (v_next < V_LIM);
                        state <= continuous_in ? SYNC_HIGH : IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/camera_capture_ctrl.md
# camera_capture_ctrl

Frame-capture sequencer between the camera pixel assembler and the frame buffer write port. Consumes the assembled 16-bit pixel stream plus registered HSYNC/VSYNC levels, aligns to a frame boundary after being armed, and emits one frame-buffer write per accepted pixel with a linear address, row/column counters and frame-complete/error status. Supports single-shot and continuous capture, and drops a partially-seen frame when armed mid-frame.

## Interface
- H_ACTIVE, 320, pixels per line written; extra pixels in a line are dropped
- V_ACTIVE, 240, lines per frame written; extra lines are dropped
- ADDR_WIDTH, 17, frame buffer address width; must satisfy 2^ADDR_WIDTH ≥ H_ACTIVE·V_ACTIVE
- clk_pixel_in  input  1  system clock; all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- valid_in  input  1  one-cycle pulse: data_in holds a complete pixel
- data_in  input  16  assembled pixel (RGB565)
- hs_in  input  1  registered camera HREF level, high during active line
- vs_in  input  1  registered camera VSYNC level, high during active frame
- arm_in  input  1  pulse: request capture of the next full frame
- continuous_in  input  1  level: keep capturing every frame after arm
- we_out  output  1  frame buffer write strobe
- addr_out  output  ADDR_WIDTH  write address, row-major, vcount·H_ACTIVE + hcount
- pixel_out  output  16  write data
- hcount_out  output  $clog2(H_ACTIVE+1)  current column within line
- vcount_out  output  $clog2(V_ACTIVE+1)  current line within frame
- busy_out  output  1  high in any state except IDLE
- frame_done_out  output  1  one-cycle pulse at end of a captured frame
- line_err_out  output  1  sticky: a line ended with fewer than H_ACTIVE pixels
- frame_err_out  output  1  sticky: a frame ended with fewer than V_ACTIVE lines

## Operation
- Edge detect: hs_prev/vs_prev registered each cycle; hs_fall = hs_prev & ~hs_in; vs_rise = ~vs_prev & vs_in; vs_fall = vs_prev & ~vs_in.
- States: IDLE, SYNC_LOW, SYNC_HIGH, CAPTURE.
- IDLE: on arm_in → SYNC_LOW; clears line_err_out, frame_err_out.
- SYNC_LOW: wait for vs_in == 0 (guarantees partial frames skipped) → SYNC_HIGH. If vs_in already 0 on entry, transition next cycle.
- SYNC_HIGH: on vs_rise → CAPTURE with hcount=0, vcount=0, addr=0.
- CAPTURE, pixel accept: valid_in & hs_in & vs_in & hcount<H_ACTIVE & vcount<V_ACTIVE → write pixel at addr, hcount+1, addr+1. Otherwise valid_in ignored.
- CAPTURE, hs_fall: if vcount<V_ACTIVE: set line_err if hcount<H_ACTIVE; vcount+1 (saturate at V_ACTIVE); hcount=0; addr = (vcount+1)·H_ACTIVE, maintained incrementally (add H_ACTIVE−hcount), no multiplier.
- CAPTURE, vs_fall: pulse frame_done_out; set frame_err if vcount<V_ACTIVE; → SYNC_HIGH if continuous_in, else IDLE.
- valid_in accept and hs_fall in the same cycle: pixel written at current addr/line first, then line advance (addr = next line base).
- hs_fall and vs_fall in the same cycle: line accounting applied before frame_err check.
- arm_in outside IDLE ignored. Dropping continuous_in mid-frame: current frame completes, then IDLE.
- Addresses never exceed H_ACTIVE·V_ACTIVE−1; no wrap.

## Timing
- Reset: state IDLE; we_out 0, addr_out 0, pixel_out 0, hcount_out 0, vcount_out 0, busy_out 0, frame_done_out 0, line_err_out 0, frame_err_out 0, hs_prev 0, vs_prev 0. Reset mid-capture aborts immediately; no further writes.
- Write latency: valid_in at cycle N → we_out, addr_out, pixel_out valid at cycle N+1 (registered); we_out high exactly one cycle.
- frame_done_out asserted cycle after vs_fall sampled; coincident with final state transition.
- hcount_out/vcount_out registered; reflect state after cycle's updates.
- Edge detection adds one cycle: a vs rise visible at cycle N enters CAPTURE at N+1; valid_in at N not captured.
- Sustained throughput: one pixel per cycle.

## Test plan
- Params H_ACTIVE=4, V_ACTIVE=3; arm, one clean 4×3 frame, data=0x0100+idx -> 12 writes, addr 0..11, data match, one frame_done_out, no errors, IDLE after.
- Arm with vs_in already high mid-frame -> no writes until vs low then high; next full frame captured at addr 0..11.
- Line of 2 pixels in row 1 -> writes row1 at addr 4,5, row 2 starts at addr 8; line_err_out=1 sticky; frame_err_out=0.
- 6 pixels per line and 5 lines -> only 12 writes, max addr 11; no errors; frame_done once.
- continuous_in=1 over three frames, deassert during frame 2 -> frames 1 and 2 written, frame_done twice, IDLE before frame 3.
- rst_in asserted at pixel 5 of frame -> next cycle we_out=0, all outputs at reset values, state IDLE; later arm_in captures normally.
